credit_sender_push_stage: RTL
=============================

// Module: credit_sender_push_stage
// PURPOSE
//  Upstream sender for cdc_fifo_flops_push_credit. Converts a ready/valid source stream into the FIFO's credit-based push
//  interface: holds the sender-side credit counter, applies withholding, runs the sender/receiver reset handshake and
//  drives registered push_valid/push_data into the FIFO push port. Single clock, push_clk domain.
// PARAMETERS
//  data_width    8                          payload width
//  fifo_depth    17                         receiver FIFO depth = max credits
//  credit_width  $clog2(fifo_depth+1)       counter width (5 at default)
// PORTS
//  push_clk               in   1   clock
//  push_rst_n             in   1   synchronous active-low reset
//  push_receiver_in_reset in   1   from FIFO; 1 = receiver not ready, credits invalid
//  push_sender_in_reset   out  1   to FIFO; 1 = sender in reset
//  push_credit            in   1   one credit returned per cycle asserted
//  push_credit_stall      out  1   to FIFO; registered copy of credit_stall_req
//  credit_stall_req       in   1   local request to pause credit return
//  in_valid               in   1   source valid
//  in_ready               out  1   source ready (combinational)
//  in_data                in   data_width   source payload
//  push_valid             out  1   to FIFO, registered
//  push_data              out  data_width   to FIFO, registered
//  credit_initial         in   credit_width credits loaded on entering ACTIVE
//  credit_withhold        in   credit_width credits never spent
//  credit_count           out  credit_width current held credits
//  credit_available       out  credit_width spendable credits
// BEHAVIOUR
//  Reset (push_rst_n=0 at posedge): state=RESET, credit_count=0, push_valid=0, push_data=0, push_sender_in_reset=1,
//   push_credit_stall=1. credit_available=0, in_ready=0.
//  FSM: RESET -> WAIT_RX (first cycle with push_rst_n=1); push_sender_in_reset=0 from WAIT_RX onward.
//   WAIT_RX -> ACTIVE when push_receiver_in_reset=0; same edge loads credit_count=credit_initial (clamped to fifo_depth).
//   ACTIVE -> WAIT_RX when push_receiver_in_reset=1: credit_count<=0, push_valid<=0, in-flight push dropped.
//  credit_available = (credit_count > credit_withhold) ? credit_count - credit_withhold : 0; combinational,
//   tracks credit_withhold changes in same cycle.
//  in_ready = (state==ACTIVE) && credit_available!=0. fire = in_valid && in_ready.
//  fire -> next edge push_valid=1, push_data=in_data (latency 1). No fire -> push_valid=0; push_data holds.
//  Counter in ACTIVE: next = credit_count + push_credit - fire. Credit and fire same cycle -> unchanged.
//   Credit with credit_count==fifo_depth and no fire -> overflow: count holds at fifo_depth.
//   push_credit ignored outside ACTIVE.
//  push_credit_stall <= credit_stall_req every cycle out of reset (1-cycle delay).
//  Back-to-back pushes at full rate while credit_available>=1; count reaching withhold drops in_ready same cycle.
// CONFIGURATION
//  CREDIT_SENDER_ERR_EN defined: adds output credit_err (1 bit), reset 0, sticky-set on overflow, cleared only by reset;
//   also set on push_credit while in WAIT_RX. Undefined: port absent, overflow silently saturates.
// TESTING
//  T1 reset: push_rst_n=0 two cycles -> push_sender_in_reset=1, push_valid=0, credit_count=0, push_credit_stall=1.
//  T2 handshake: release reset, receiver_in_reset=1 5 cycles then 0, credit_initial=17 -> ACTIVE, credit_count=17,
//   credit_available=17, in_ready=1 next cycle.
//  T3 exhaust: in_valid=1 data 0x20..0x30, no credits -> 17 pushes, push_data 0x20 one cycle after first fire,
//   credit_count=0, in_ready=0 on 18th cycle.
//  T4 withhold: credit_withhold=2, count 17 -> credit_available=15; 15 fires then in_ready=0, credit_count=2.
//  T5 simultaneous: count 5, fire + push_credit same cycle -> count stays 5; credit only at count 17 -> stays 17,
//   credit_err=1 with CREDIT_SENDER_ERR_EN.
//  T6 receiver reset mid-stream: push_receiver_in_reset=1 during fires -> next edge push_valid=0, count=0, WAIT_RX;
//   deassert -> count reloads 17.

Source files
------------

// File: rtl/credit_sender_push_stage.sv
// Credit-based push sender: ready/valid source to credit FIFO push port.
// Optional sticky credit_err output when CREDIT_SENDER_ERR_EN is defined.
module credit_sender_push_stage #(
    parameter int data_width   = 8,
    parameter int fifo_depth   = 17,
    parameter int credit_width = $clog2(fifo_depth + 1)
) (
    input  logic                    push_clk,
    input  logic                    push_rst_n,
    input  logic                    push_receiver_in_reset,
    output logic                    push_sender_in_reset,
    input  logic                    push_credit,
    output logic                    push_credit_stall,
    input  logic                    credit_stall_req,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [data_width-1:0]   in_data,
    output logic                    push_valid,
    output logic [data_width-1:0]   push_data,
    input  logic [credit_width-1:0] credit_initial,
    input  logic [credit_width-1:0] credit_withhold,
    output logic [credit_width-1:0] credit_count,
`ifdef CREDIT_SENDER_ERR_EN
    output logic                    credit_err,
`endif
    output logic [credit_width-1:0] credit_available
);

    typedef enum logic [1:0] {
        ST_RESET,
        ST_WAIT_RX,
        ST_ACTIVE
    } state_t;

    localparam logic [credit_width-1:0] DEPTH = credit_width'(fifo_depth);

    state_t                  state_q, state_d;
    logic [credit_width-1:0] count_q, count_d;
    logic                    pv_q, pv_d;
    logic [data_width-1:0]   pd_q, pd_d;
    logic                    sir_q, sir_d;
    logic                    stall_q, stall_d;
    logic                    fire;
`ifdef CREDIT_SENDER_ERR_EN
    logic                    err_q, err_d;
`endif

    always_comb begin
        credit_available = '0;
        if (count_q > credit_withhold) begin
            credit_available = count_q - credit_withhold;
        end
    end

    assign in_ready = (state_q == ST_ACTIVE) && (credit_available != '0);
    assign fire     = in_valid && in_ready;

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        pv_d    = 1'b0;
        pd_d    = pd_q;
        sir_d   = 1'b0;
        stall_d = credit_stall_req;
`ifdef CREDIT_SENDER_ERR_EN
        err_d   = err_q;
`endif
        unique case (state_q)
            ST_RESET: begin
                state_d = ST_WAIT_RX;
            end
            ST_WAIT_RX: begin
`ifdef CREDIT_SENDER_ERR_EN
                if (push_credit) begin
                    err_d = 1'b1;
                end
`endif
                if (!push_receiver_in_reset) begin
                    state_d = ST_ACTIVE;
                    count_d = (credit_initial > DEPTH) ? DEPTH
                                                       : credit_initial;
                end
            end
            ST_ACTIVE: begin
                if (push_receiver_in_reset) begin
                    // receiver lost: credits are void, push is dropped
                    state_d = ST_WAIT_RX;
                    count_d = '0;
                end else begin
                    pv_d = fire;
                    if (fire) begin
                        pd_d = in_data;
                    end
                    if (push_credit && !fire) begin
                        if (count_q == DEPTH) begin
`ifdef CREDIT_SENDER_ERR_EN
                            err_d = 1'b1;
`endif
                        end else begin
                            count_d = count_q + 1'b1;
                        end
                    end else if (fire && !push_credit) begin
                        count_d = count_q - 1'b1;
                    end
                end
            end
            default: begin
                state_d = ST_RESET;
            end
        endcase
    end

    always_ff @(posedge push_clk) begin
        if (!push_rst_n) begin
            state_q <= ST_RESET;
            count_q <= '0;
            pv_q    <= 1'b0;
            pd_q    <= '0;
            sir_q   <= 1'b1;
            stall_q <= 1'b1;
`ifdef CREDIT_SENDER_ERR_EN
            err_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            pv_q    <= pv_d;
            pd_q    <= pd_d;
            sir_q   <= sir_d;
            stall_q <= stall_d;
`ifdef CREDIT_SENDER_ERR_EN
            err_q   <= err_d;
`endif
        end
    end

    assign credit_count         = count_q;
    assign push_valid           = pv_q;
    assign push_data            = pd_q;
    assign push_sender_in_reset = sir_q;
    assign push_credit_stall    = stall_q;
`ifdef CREDIT_SENDER_ERR_EN
    assign credit_err           = err_q;
`endif

endmodule
